// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction-fetch initiator with credit-based flow control.
//
// State (derived from drop_cnt, not separately registered)
//   state  | meaning
//   RUN    | drop_cnt == 0, responses are pushed into the buffer
//   SQUASH | drop_cnt != 0, stale responses from before a redirect are discarded
//
// Ports
//   clk_i, rst_ni                    clock, async active-low reset
//   redirect_valid_i, redirect_pc_i  one-cycle squash and restart pulse
//   imem_req_*                       valid/ready word read request channel
//   imem_rsp_*                       in-order response channel (no back-pressure)
//   inst_*                           valid/ready {pc, instruction} stream to decode
module fetch_unit #(
  parameter int                   AddrWidth = 32,
  parameter int                   Width     = 32,
  parameter int                   DepthLog2 = 2,
  parameter logic [AddrWidth-1:0] ResetPc   = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 redirect_valid_i,
  input  logic [AddrWidth-1:0] redirect_pc_i,
  output logic                 imem_req_valid_o,
  input  logic                 imem_req_ready_i,
  output logic [AddrWidth-1:0] imem_req_addr_o,
  input  logic                 imem_rsp_valid_i,
  input  logic [Width-1:0]     imem_rsp_data_i,
  output logic                 inst_valid_o,
  input  logic                 inst_ready_i,
  output logic [Width-1:0]     inst_data_o,
  output logic [AddrWidth-1:0] inst_pc_o
);

  localparam int CW = DepthLog2 + 1;
  localparam logic [CW:0] DepthCnt = (CW+1)'(2**DepthLog2);

  typedef enum logic {ST_RUN, ST_SQUASH} state_e;

  logic                 r_run;
  logic [AddrWidth-1:0] r_req_pc;
  logic [AddrWidth-1:0] r_rsp_pc;
  logic [CW-1:0]        r_outstanding;
  logic [CW-1:0]        r_drop_cnt;
  logic [CW-1:0]        r_count;
  logic [DepthLog2-1:0] r_wptr;
  logic [DepthLog2-1:0] r_rptr;
  logic [AddrWidth-1:0] r_buf_pc   [2**DepthLog2];
  logic [Width-1:0]     r_buf_data [2**DepthLog2];

  state_e      w_state;
  logic [CW:0] w_credit_sum;
  logic        w_req_valid;
  logic        w_issue;
  logic        w_rsp;
  logic        w_pop;
  logic        w_push;
  logic [CW-1:0] w_outstanding_nxt;
  logic [CW-1:0] w_drop_nxt;

  // r_run holds the request channel idle until the first clock after reset release.
  assign w_credit_sum = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_req_valid  = r_run && (w_credit_sum < DepthCnt) && !redirect_valid_i;
  assign w_issue      = w_req_valid && imem_req_ready_i;
  // Guarding on outstanding keeps the counter from wrapping on a protocol violation.
  assign w_rsp        = imem_rsp_valid_i && (r_outstanding != '0);
  assign w_pop        = (r_count != '0) && inst_ready_i;
  assign w_state      = (r_drop_cnt != '0) ? ST_SQUASH : ST_RUN;

  always_comb begin
    w_push            = 1'b0;
    w_drop_nxt        = r_drop_cnt;
    w_outstanding_nxt = r_outstanding + CW'(w_issue) - CW'(w_rsp);
    case (w_state)
      ST_RUN:    if (w_rsp && !redirect_valid_i) w_push = 1'b1;
      ST_SQUASH: if (w_rsp) w_drop_nxt = r_drop_cnt - CW'(1);
      default:   w_push = 1'b0;
    endcase
    // A response in the redirect cycle is already excluded from w_outstanding_nxt,
    // so it is dropped without being counted.
    if (redirect_valid_i) w_drop_nxt = w_outstanding_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_run         <= 1'b0;
      r_req_pc      <= ResetPc;
      r_rsp_pc      <= ResetPc;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_run         <= 1'b1;
      r_outstanding <= w_outstanding_nxt;
      r_drop_cnt    <= w_drop_nxt;
      if (redirect_valid_i) begin
        r_req_pc <= redirect_pc_i;
        r_rsp_pc <= redirect_pc_i;
        r_count  <= '0;
        r_wptr   <= '0;
        r_rptr   <= '0;
      end else begin
        if (w_issue) r_req_pc <= r_req_pc + AddrWidth'(4);
        if (w_push)  r_rsp_pc <= r_rsp_pc + AddrWidth'(4);
        if (w_push)  r_wptr   <= r_wptr + DepthLog2'(1);
        if (w_pop)   r_rptr   <= r_rptr + DepthLog2'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Buffer storage needs no reset; r_count qualifies every entry.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_buf_pc[r_wptr]   <= r_rsp_pc;
      r_buf_data[r_wptr] <= imem_rsp_data_i;
    end
  end

  assign imem_req_valid_o = w_req_valid;
  assign imem_req_addr_o  = r_req_pc;
  assign inst_valid_o     = (r_count != '0);
  assign inst_data_o      = r_buf_data[r_rptr];
  assign inst_pc_o        = r_buf_pc[r_rptr];

  a_rsp_without_request: assert property (
    @(posedge clk_i) disable iff (!rst_ni) imem_rsp_valid_i |-> (r_outstanding != '0)
  );

endmodule
